// File: rtl/pic_pkg.sv
// Shared constants for the PIC-style core data-memory stage: SFR addresses,
// STATUS bit positions and small address-classification helpers.
package pic_pkg;

   localparam logic [6:0] ADDR_INDF   = 7'h00;
   localparam logic [6:0] ADDR_TMR0   = 7'h01;
   localparam logic [6:0] ADDR_STATUS = 7'h03;
   localparam logic [6:0] ADDR_FSR    = 7'h04;
   localparam logic [6:0] ADDR_PORTA  = 7'h05;
   localparam logic [6:0] ADDR_PORTB  = 7'h06;
   localparam logic [6:0] GPR_BASE    = 7'h0C;
   localparam logic [6:0] GPR_LAST    = 7'h7F;

   localparam int unsigned ST_C  = 0;
   localparam int unsigned ST_DC = 1;
   localparam int unsigned ST_Z  = 2;
   localparam int unsigned ST_W  = 3;

   function automatic logic is_gpr(input logic [6:0] a);
      return a >= GPR_BASE;
   endfunction

   function automatic logic is_indf(input logic [6:0] a);
      return a == ADDR_INDF;
   endfunction

endpackage

// File: rtl/file_reg_if.sv
// File-access bus between decode/ALU and the register file: address, write
// data, write strobe and the combinational read-back operand.
interface file_reg_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 8
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] ans;
   logic              f_we;
   logic [DATA_W-1:0] f;

   modport master (output address, output ans, output f_we, input f);
   modport slave  (input address, input ans, input f_we, output f);
endinterface

// File: rtl/file_reg_tmr0_counter.sv
// Free-running TMR0 with post-write inhibit and a registered one-cycle
// overflow pulse on the 0xFF -> 0x00 increment.
module tmr0_counter #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TMR_INHIBIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_val,
   output logic [DATA_W-1:0] count,
   output logic              ovf
);

   // Inhibit is a thermometer shift register: each set bit holds the count
   // for one further cycle, so a reload simply refills it.
   logic [TMR_INHIBIT-1:0] hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         hold  <= '0;
         ovf   <= 1'b0;
      end else if (load) begin
         count <= load_val;
         hold  <= '1;
         ovf   <= 1'b0;
      end else if (hold[0]) begin
         hold  <= hold >> 1;
         ovf   <= 1'b0;
      end else begin
         count <= count + DATA_W'(1);
         ovf   <= &count;
      end
   end

endmodule

// File: rtl/file_reg.sv
// Data-memory stage: address decode with INDF/FSR indirection, GPR array,
// STATUS with flag-update priority, PORTA/PORTB and the TMR0 counter.
module file_reg
   import pic_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned TMR_INHIBIT = 2
) (
   input  logic              clk,
   input  logic              reset,
   file_reg_if.slave         bus,
   input  logic              z_we,
   input  logic              z_in,
   input  logic              c_we,
   input  logic              c_in,
   input  logic              dc_in,
   input  logic [DATA_W-1:0] port_in,
   output logic              carry,
   output logic [DATA_W-1:0] status,
   output logic [DATA_W-1:0] port_out,
   output logic              tmr0_ovf
);

   localparam int unsigned GPR_LO = int'(GPR_BASE);
   localparam int unsigned GPR_HI = (1 << ADDR_W) - 1;

   logic [DATA_W-1:0] gpr [GPR_LO:GPR_HI];
   logic [DATA_W-1:0] fsr;
   logic [DATA_W-1:0] portb;
   logic [ST_W-1:0]   st;
   logic [ST_W-1:0]   st_next;
   logic [ADDR_W-1:0] eff;
   logic [DATA_W-1:0] tmr_count;
   logic              tmr_load;
   logic [DATA_W-1:0] rd;

   // INDF redirects through FSR; FSR=0 lands back on INDF, which reads zero
   // and has no storage, so recursion resolves to a dead access.
   always_comb begin
      eff = bus.address;
      if (is_indf(7'(bus.address))) eff = fsr[ADDR_W-1:0];
   end

   assign tmr_load = bus.f_we && !reset && (eff == ADDR_W'(ADDR_TMR0));

   tmr0_counter #(
      .DATA_W      (DATA_W),
      .TMR_INHIBIT (TMR_INHIBIT)
   ) u_tmr0 (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (bus.ans),
      .count    (tmr_count),
      .ovf      (tmr0_ovf)
   );

   // Flag strobes from the ALU take precedence over a direct STATUS write.
   always_comb begin
      st_next = st;
      if (bus.f_we && eff == ADDR_W'(ADDR_STATUS)) st_next = bus.ans[ST_W-1:0];
      if (c_we) begin
         st_next[ST_C]  = c_in;
         st_next[ST_DC] = dc_in;
      end
      if (z_we) st_next[ST_Z] = z_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsr   <= '0;
         portb <= '0;
         st    <= '0;
      end else begin
         st <= st_next;
         if (bus.f_we) begin
            if (eff == ADDR_W'(ADDR_FSR))   fsr   <= bus.ans;
            if (eff == ADDR_W'(ADDR_PORTB)) portb <= bus.ans;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = GPR_LO; i <= GPR_HI; i++) gpr[ADDR_W'(i)] <= '0;
      end else if (bus.f_we && is_gpr(7'(eff))) begin
         gpr[eff] <= bus.ans;
      end
   end

   always_comb begin
      rd = '0;
      if (is_gpr(7'(eff))) begin
         rd = gpr[eff];
      end else begin
         case (eff)
            ADDR_W'(ADDR_TMR0):   rd = tmr_count;
            ADDR_W'(ADDR_STATUS): rd = status;
            ADDR_W'(ADDR_FSR):    rd = fsr;
            ADDR_W'(ADDR_PORTA):  rd = port_in;
            ADDR_W'(ADDR_PORTB):  rd = portb;
            default:              rd = '0;
         endcase
      end
   end

   assign bus.f    = rd;
   assign status   = {{(DATA_W-ST_W){1'b0}}, st};
   assign carry    = st[ST_C];
   assign port_out = portb;

endmodule
